pattern_sequencer: RTL and testbench

//  Playback stage directly downstream of the pattern buffers block.
//  - Walks the 3-entry pattern sequence.
//  - Drives buffer pointer bufp and field pointer fieldp into the buffers block.
//  - Captures the returned field_byte.
//  - Presents each byte on a valid/ready stream to the output serializer.

---
 rtl/pattern_sequencer_if.sv | 11 +
 rtl/pattern_sequencer.sv | 177 +++++++++++++++++
 tb/tb_pattern_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_sequencer_if.sv
// Byte stream from the pattern sequencer to the output serializer.
// The master drives data/valid/last and the consumer answers with ready.
interface pattern_sequencer_if;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (output out_byte, output out_valid, output out_last, input out_ready);
    modport slave  (input out_byte, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/pattern_sequencer.sv
// Pattern playback: walks the sequence entries, reads bytes from the pattern buffers and streams them out.
// Optional handshake counter output bytes_sent is built when PATSEQ_BYTECNT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// ENTRY | load buffer index and repeat count of the current entry
// FETCH | read-wait cycle; byte captured at end of cycle
// EMIT  | byte presented on the stream until accepted
module pattern_sequencer #(
    parameter int NFIELDS = 27,
    parameter int NSEQ    = 3,
    parameter int FIELD_W = 5,
    parameter int BUF_W   = 3
) (
    input  logic                sclk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    input  logic [8*NSEQ-1:0]   seq_in,
    input  logic [7:0]          field_byte,
    output logic [BUF_W-1:0]    bufp,
    output logic [FIELD_W-1:0]  fieldp,
    output logic                busy,
    output logic                done,
`ifdef PATSEQ_BYTECNT_EN
    output logic [15:0]         bytes_sent,
`endif
    pattern_sequencer_if.master out_if
);

    localparam int SEQ_W = (NSEQ > 1) ? $clog2(NSEQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_FETCH, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [SEQ_W-1:0]   seq_idx_q, seq_idx_d;
    logic [3:0]         rep_cnt_q, rep_cnt_d;
    logic [BUF_W-1:0]   bufp_q, bufp_d;
    logic [FIELD_W-1:0] fieldp_q, fieldp_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               done_q, done_d;
    logic               stop_pend_q, stop_pend_d;

    logic [7:0] entry;
    logic       hs;
    logic       last_field;
    logic       terminal;

    always_comb begin
        entry = 8'h00;
        for (int i = 0; i < NSEQ; i++) begin
            if (seq_idx_q == SEQ_W'(i)) entry = seq_in[8*i +: 8];
        end
    end

    assign hs         = (state_q == S_EMIT) && out_if.out_ready;
    assign last_field = (fieldp_q == FIELD_W'(NFIELDS - 1));
    assign terminal   = entry[7] || (seq_idx_q == SEQ_W'(NSEQ - 1));

    always_comb begin
        state_d     = state_q;
        seq_idx_d   = seq_idx_q;
        rep_cnt_d   = rep_cnt_q;
        bufp_d      = bufp_q;
        fieldp_d    = fieldp_q;
        out_byte_d  = out_byte_q;
        done_d      = 1'b0;
        stop_pend_d = stop_pend_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    seq_idx_d = '0;
                    state_d   = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    bufp_d    = entry[BUF_W-1:0];
                    rep_cnt_d = entry[6:3];
                    fieldp_d  = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    out_byte_d = field_byte;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                // A stop seen while stalled is remembered so valid is never withdrawn.
                if (stop) stop_pend_d = 1'b1;
                if (hs) begin
                    stop_pend_d = 1'b0;
                    if (stop || stop_pend_q) begin
                        state_d = S_IDLE;
                    end else if (!last_field) begin
                        fieldp_d = fieldp_q + FIELD_W'(1);
                        state_d  = S_FETCH;
                    end else if (rep_cnt_q != 4'd0) begin
                        rep_cnt_d = rep_cnt_q - 4'd1;
                        fieldp_d  = '0;
                        state_d   = S_FETCH;
                    end else if (terminal) begin
                        if (loop) begin
                            seq_idx_d = '0;
                            state_d   = S_ENTRY;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        seq_idx_d = seq_idx_q + SEQ_W'(1);
                        state_d   = S_ENTRY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            seq_idx_q   <= '0;
            rep_cnt_q   <= '0;
            bufp_q      <= '0;
            fieldp_q    <= '0;
            out_byte_q  <= '0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_idx_q   <= seq_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            bufp_q      <= bufp_d;
            fieldp_q    <= fieldp_d;
            out_byte_q  <= out_byte_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign bufp             = bufp_q;
    assign fieldp           = fieldp_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign out_if.out_byte  = out_byte_q;
    assign out_if.out_valid = (state_q == S_EMIT);
    assign out_if.out_last  = (state_q == S_EMIT) && last_field && (rep_cnt_q == 4'd0) && terminal;

`ifdef PATSEQ_BYTECNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if ((state_q == S_IDLE) && start && !stop) begin
            byte_cnt_d = '0;
        end else if (hs && (byte_cnt_q != 16'hFFFF)) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) byte_cnt_q <= '0;
        else       byte_cnt_q <= byte_cnt_d;
    end

    assign bytes_sent = byte_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: expected byte stream built from the sequence rules.
module tb_pattern_sequencer;
    localparam int NF = 27;

    logic        sclk = 1'b0;
    logic        reset, start, stop, loop;
    logic [23:0] seq_in;
    logic [7:0]  field_byte;
    logic [2:0]  bufp;
    logic [4:0]  fieldp;
    logic        busy, done;
`ifdef PATSEQ_BYTECNT_EN
    logic [15:0] bytes_sent;
`endif

    pattern_sequencer_if ifc();

    pattern_sequencer dut (
        .sclk       (sclk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .seq_in     (seq_in),
        .field_byte (field_byte),
        .bufp       (bufp),
        .fieldp     (fieldp),
        .busy       (busy),
        .done       (done),
`ifdef PATSEQ_BYTECNT_EN
        .bytes_sent (bytes_sent),
`endif
        .out_if     (ifc.master)
    );

    always #5 sclk = ~sclk;

    // Pattern buffers model: data for the current pointers is stable through FETCH.
    logic [7:0] mem [0:7][0:31];
    assign field_byte = mem[bufp][fieldp];

    typedef struct packed {
        logic [2:0] b;
        logic [4:0] f;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          hs_cnt, done_cnt, rdy_mode, stall_left, stop_at, n, n_exp;
    logic        start_now, stop_now, stop_fired, reset_fired, prev_stall;
    logic [15:0] prev_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pass through the sequence as the playback rules describe it.
    task automatic model_pass(input logic [23:0] s);
        logic [7:0] ent;
        exp_t       t;
        for (int e = 0; e < 3; e++) begin
            ent = s[8*e +: 8];
            for (int r = 0; r <= int'(ent[6:3]); r++) begin
                for (int f = 0; f < NF; f++) begin
                    t.b = ent[2:0];
                    t.f = 5'(f);
                    t.d = mem[ent[2:0]][f];
                    t.l = 1'b0;
                    exp_q.push_back(t);
                end
            end
            if (ent[7] || e == 2) begin
                t = exp_q.pop_back();
                t.l = 1'b1;
                exp_q.push_back(t);
                break;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        logic rdy;
        @(negedge sclk);
        if (prev_stall)
            check("hold", 32'({ifc.out_valid, bufp, fieldp, ifc.out_byte}), 32'({1'b1, prev_out}));
        rdy   = 1'b1;
        stop  = stop_now;
        reset = 1'b0;
        case (rdy_mode)
            1: rdy = ($urandom_range(0, 99) < 70);
            2: if (ifc.out_valid && fieldp == 5'd10 && stall_left > 0) begin
                   rdy = 1'b0;
                   stall_left--;
               end
            3: if (ifc.out_valid && hs_cnt == stop_at && !stop_fired) begin
                   rdy = 1'b0;
                   stop = 1'b1;
                   stop_fired = 1'b1;
               end
            5: if (ifc.out_valid && fieldp == 5'd5 && !reset_fired) begin
                   rdy = 1'b0;
                   reset = 1'b1;
                   reset_fired = 1'b1;
               end
            default: ;
        endcase
        if (ifc.out_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("byte", 32'({bufp, fieldp, ifc.out_byte, ifc.out_last}), 32'(e));
            end
            hs_cnt++;
        end
        if (done) done_cnt++;
        prev_stall    = ifc.out_valid && !rdy && !reset;
        prev_out      = {bufp, fieldp, ifc.out_byte};
        ifc.out_ready = rdy;
        start         = start_now;
    endtask

    task automatic run_to_idle(input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (busy && cnt < budget);
        check("timeout_busy", 32'(busy), 32'd0);
    endtask

    task automatic play(input logic [23:0] s, input logic lp, input int mode, output int cnt);
        seq_in     = s;
        loop       = lp;
        rdy_mode   = mode;
        hs_cnt     = 0;
        done_cnt   = 0;
        prev_stall = 1'b0;
        start_now  = 1'b1;
        step();
        start_now  = 1'b0;
        run_to_idle(20000, cnt);
    endtask

    localparam logic [23:0] S1 = {8'h00, 8'h00, 8'h80};
    localparam logic [23:0] S2 = {8'h81, 8'h0B, 8'h02};

    initial begin
        logic [23:0] rs;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; seq_in = '0;
        ifc.out_ready = 1'b0;
        start_now = 1'b0; stop_now = 1'b0; stop_fired = 1'b0; reset_fired = 1'b0;
        prev_stall = 1'b0; prev_out = '0;
        hs_cnt = 0; done_cnt = 0; rdy_mode = 0; stall_left = 0; stop_at = 0;
        for (int b = 0; b < 8; b++)
            for (int f = 0; f < 32; f++)
                mem[b][f] = (f < NF) ? 8'($urandom) : 8'h00;

        repeat (3) @(negedge sclk);
        check("reset_outputs", 32'({busy, done, ifc.out_valid, ifc.out_last, bufp, fieldp, ifc.out_byte}), 32'd0);

        // single entry, ready held high
        model_pass(S1);
        play(S1, 1'b0, 0, n);
        check("t1_cycles", 32'(n), 32'(1 + 1 + 2 * 27));
        check("t1_bytes", 32'(hs_cnt), 32'd27);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_queue_left", 32'(exp_q.size()), 32'd0);
        step(); step();
        check("t1_done_pulse", 32'(done_cnt), 32'd1);
        check("t1_idle", 32'({busy, ifc.out_valid}), 32'd0);

        // three entries with a repeat
        model_pass(S2);
        play(S2, 1'b0, 0, n);
        check("t2_cycles", 32'(n), 32'(1 + 3 + 2 * 108));
        check("t2_bytes", 32'(hs_cnt), 32'd108);
        check("t2_done", 32'(done_cnt), 32'd1);
        check("t2_queue_left", 32'(exp_q.size()), 32'd0);
`ifdef PATSEQ_BYTECNT_EN
        check("t6_bytes_sent", 32'(bytes_sent), 32'd108);
        start_now = 1'b1; step(); start_now = 1'b0;
        stop_now = 1'b1; step();
        check("t6_bytes_cleared", 32'(bytes_sent), 32'd0);
        stop_now = 1'b0; step();
`endif

        // consumer stall at field 10
        stall_left = 5;
        model_pass(S1);
        play(S1, 1'b0, 2, n);
        check("t3_stalled", 32'(stall_left), 32'd0);
        check("t3_bytes", 32'(hs_cnt), 32'd27);
        check("t3_done", 32'(done_cnt), 32'd1);
        check("t3_queue_left", 32'(exp_q.size()), 32'd0);

        // looping, then stop while a byte is stalled
        model_pass(S1);
        model_pass(S1);
        stop_at = 39;
        stop_fired = 1'b0;
        play(S1, 1'b1, 3, n);
        check("t4_bytes", 32'(hs_cnt), 32'd40);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        check("t4_queue_left", 32'(exp_q.size()), 32'd14);
        check("t4_idle", 32'({busy, ifc.out_valid}), 32'd0);
        exp_q.delete();
        loop = 1'b0;

        // start and stop together, stop in ENTRY, stop in FETCH
        rdy_mode = 0; hs_cnt = 0; done_cnt = 0;
        start_now = 1'b1; stop_now = 1'b1; step();
        start_now = 1'b0; stop_now = 1'b0; step();
        check("startstop_idle", 32'(busy), 32'd0);
        start_now = 1'b1; step(); start_now = 1'b0;
        stop_now = 1'b1; step(); stop_now = 1'b0; step();
        check("stop_entry_idle", 32'({busy, ifc.out_valid}), 32'd0);
        start_now = 1'b1; step(); start_now = 1'b0;
        step();
        stop_now = 1'b1; step(); stop_now = 1'b0; step();
        check("stop_fetch_idle", 32'({busy, ifc.out_valid}), 32'd0);
        check("stop_no_bytes", 32'({hs_cnt[15:0], done_cnt[15:0]}), 32'd0);

        // reset while emitting field 5, then replay
        model_pass(S1);
        reset_fired = 1'b0;
        play(S1, 1'b0, 5, n);
        check("t5_reset_fired", 32'(reset_fired), 32'd1);
        check("t5_bytes_before", 32'(hs_cnt), 32'd5);
        check("t5_outputs", 32'({busy, done, ifc.out_valid, ifc.out_last, bufp, fieldp, ifc.out_byte}), 32'd0);
        exp_q.delete();
        model_pass(S1);
        play(S1, 1'b0, 0, n);
        check("t5_replay_cycles", 32'(n), 32'd56);
        check("t5_replay_done", 32'(done_cnt), 32'd1);
        check("t5_queue_left", 32'(exp_q.size()), 32'd0);

        // random sequences with random consumer backpressure
        for (int k = 0; k < 3; k++) begin
            for (int e = 0; e < 3; e++)
                rs[8*e +: 8] = {1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            model_pass(rs);
            n_exp = exp_q.size();
            play(rs, 1'b0, 1, n);
            check("rnd_bytes", 32'(hs_cnt), 32'(n_exp));
            check("rnd_done", 32'(done_cnt), 32'd1);
            check("rnd_queue_left", 32'(exp_q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, observed %0d assertions", n_assert);
        $fatal(1, "timeout");
    end

endmodule
